mod_determinante_3x3_seq: RTL and testbench
===========================================

# mod_determinante_3x3_seq

Sequential 3x3 determinant unit for the coprocessor's determinant path. It captures nine 8-bit two's-complement matrix elements on a start handshake. It evaluates the determinant by cofactor expansion along row 0, using one shared 8x8 multiplier over ten cycles, and returns an 8-bit result modulo 256. This uses the same wrap-around arithmetic as the 2x2 determinant unit, so 1·4 − 2·3 reads as 254. It sits between the instruction decoder, which issues `start`, and the result write-back, which consumes `done`/`resultado`.

## Interface
- No parameters; data width fixed at 8 bits per element.
- `clk`  in  1  — sole clock; all state updates on rising edge.
- `rst`  in  1  — reset is synchronous and active-high.
- `start`  in  1  — request; sampled only when `busy`=0.
- `matriz`  in  72  — elements row-major, m00=`matriz[7:0]`, m01=`[15:8]`, … m22=`[71:64]`; sampled only on an accepted start.
- `busy`  out  1  — operation in progress; start ignored while high.
- `done`  out  1  — single-cycle pulse; `resultado` valid from this cycle.
- `resultado`  out  8  — determinant mod 256, two's complement.
- `zero`  out  1  — 1 when `resultado`==0 (singular, modulo 256); updated together with `resultado`.

## Operation
- Formula (all intermediates truncated to 8 bits, wrap-around, no saturation):
  - M0 = m11·m22 − m12·m21
  - M1 = m10·m22 − m12·m20
  - M2 = m10·m21 − m11·m20
  - det = m00·M0 − m01·M1 + m02·M2
- Low 8 bits of the product are identical for signed and unsigned operands, so one unsigned multiplier is used.
- FSM states: IDLE, MINOR, COF, DONE.
- **IDLE:** `busy`=0. On `start`=1, latch all nine elements into an internal register. Clear the accumulator and step counter, then go to MINOR. Later changes on `matriz` have no effect.
- **MINOR:** 6 cycles, step 0..5, one product per cycle, in order:
  - m11·m22, m12·m21 → M0
  - m10·m22, m12·m20 → M1
  - m10·m21, m11·m20 → M2
  - Even step stores the product; odd step writes product-difference to the minor register. Then go to COF.
- **COF:** 3 cycles, step 0..2.
  - Step 0: acc = m00·M0.
  - Step 1: acc = acc − m01·M1.
  - Step 2: acc = acc + m02·M2.
  - Then go to DONE.
- **DONE:** 1 cycle. `done`=1, `resultado`/`zero` updated from acc, `busy`=0.
  - A `start` in this cycle is accepted, with the same behaviour as IDLE, and goes to MINOR.
  - Otherwise go to IDLE.
- `resultado` and `zero` hold their value until the next `done`.

## Timing
- Reset values (first edge with `rst`=1):
  - state = IDLE, `busy`=0, `done`=0, `resultado`=8'h00, `zero`=1.
  - Internal registers cleared.
- Reset has priority over `start` in the same cycle.
- Reset mid-operation aborts immediately. No `done` is issued, and `resultado` is cleared to 0.
- Let cycle 0 be the edge at which `start` is accepted.
  - `busy`=1 in cycles 1..9.
  - `done`=1 in cycle 10 only.
  - Latency is 10 cycles.
- Back-to-back throughput: start accepted in the DONE cycle gives one result every 10 cycles.
- `start` held high continuously therefore restarts every 10 cycles.
- `start` while `busy`=1 is ignored and not queued.
- `done` never coincides with `busy`=1.

## Test plan
- Identity matrix (m00=m11=m22=1, others 0), start pulse:
  - `busy` high 9 cycles; `done` in cycle 10.
  - `resultado`=1, `zero`=0.
- Rows [1,2,3],[4,5,6],[7,8,9] → `resultado`=0, `zero`=1.
- Rows [2,0,1],[1,3,2],[1,1,2] → `resultado`=6.
- Negative and wrap cases:
  - diag(−1,2,3), i.e. m00=8'hFF → `resultado`=8'hFA (−6).
  - diag(10,10,10) → `resultado`=232 (1000 mod 256).
- Handshake:
  - Start identity; at cycle 3 pulse `start` with diag(2,2,2) and change `matriz`. The result must still be 1 and exactly one `done` is issued.
  - Then start diag(2,2,2) in the DONE cycle: next `done` comes 10 cycles later with `resultado`=8.
- Reset:
  - Start the [2,0,1] matrix, assert `rst` at cycle 4 for one cycle.
  - Required: `busy`=0, no `done`, `resultado`=0, `zero`=1.
  - A new start afterwards computes correctly (6).

Source files
------------

// File: rtl/mod_determinante_3x3_seq.sv
// Sequential 3x3 determinant, cofactor expansion along row 0.
// One shared 8x8 multiplier, ten cycles per result, mod-256 arithmetic.
module mod_determinante_3x3_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [71:0] matriz,
  output logic        busy,
  output logic        done,
  output logic [7:0]  resultado,
  output logic        zero
);

  typedef enum logic [1:0] {
    IDLE,
    MINOR,
    COF,
    DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_step;
  logic [7:0]  r_m [0:8];
  logic [7:0]  r_mn [0:2];
  logic [7:0]  r_prod;
  logic [7:0]  r_acc;
  logic [7:0]  r_res;
  logic        r_zero;
  logic [7:0]  w_a;
  logic [7:0]  w_b;
  logic [7:0]  w_prod;
  logic [7:0]  w_sum;
  logic        w_accept;

  assign w_accept = start &&
    ((r_state == IDLE) || (r_state == DONE));

  // Low byte of the product is sign-agnostic.
  assign w_prod = w_a * w_b;
  assign w_sum  = r_acc + w_prod;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (start) w_next = MINOR;
      MINOR: if (r_step == 3'd5) w_next = COF;
      COF:   if (r_step == 3'd2) w_next = DONE;
      DONE:  w_next = start ? MINOR : IDLE;
    endcase
  end

  always_comb begin
    w_a = '0;
    w_b = '0;
    unique case (r_state)
      MINOR: begin
        case (r_step)
          3'd0: begin w_a = r_m[4]; w_b = r_m[8]; end
          3'd1: begin w_a = r_m[5]; w_b = r_m[7]; end
          3'd2: begin w_a = r_m[3]; w_b = r_m[8]; end
          3'd3: begin w_a = r_m[5]; w_b = r_m[6]; end
          3'd4: begin w_a = r_m[3]; w_b = r_m[7]; end
          3'd5: begin w_a = r_m[4]; w_b = r_m[6]; end
          default: ;
        endcase
      end
      COF: begin
        case (r_step)
          3'd0: begin w_a = r_m[0]; w_b = r_mn[0]; end
          3'd1: begin w_a = r_m[1]; w_b = r_mn[1]; end
          3'd2: begin w_a = r_m[2]; w_b = r_mn[2]; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) r_m[i] <= '0;
      for (int i = 0; i < 3; i++) r_mn[i] <= '0;
      r_step <= '0;
      r_prod <= '0;
      r_acc  <= '0;
      r_res  <= '0;
      r_zero <= 1'b1;
    end else if (w_accept) begin
      for (int i = 0; i < 9; i++)
        r_m[i] <= matriz[8*i +: 8];
      r_step <= '0;
      r_acc  <= '0;
    end else begin
      unique case (r_state)
        MINOR: begin
          // Even step parks the first product, odd step forms the minor.
          if (!r_step[0]) r_prod <= w_prod;
          else r_mn[r_step[2:1]] <= r_prod - w_prod;
          r_step <= (r_step == 3'd5) ? 3'd0 : r_step + 3'd1;
        end
        COF: begin
          case (r_step)
            3'd0: r_acc <= w_prod;
            3'd1: r_acc <= r_acc - w_prod;
            3'd2: begin
              r_acc  <= w_sum;
              r_res  <= w_sum;
              r_zero <= (w_sum == 8'h00);
            end
            default: ;
          endcase
          r_step <= (r_step == 3'd2) ? 3'd0 : r_step + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state == MINOR) || (r_state == COF);
  assign done      = (r_state == DONE);
  assign resultado = r_res;
  assign zero      = r_zero;

endmodule

// File: tb/tb_mod_determinante_3x3_seq.sv
// Bench for mod_determinante_3x3_seq: table vectors, random
// matrices against an integer determinant model, handshake/reset cases.
module tb_mod_determinante_3x3_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [71:0] matriz;
  logic        busy;
  logic        done;
  logic [7:0]  resultado;
  logic        zero;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  mod_determinante_3x3_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .matriz   (matriz),
    .busy     (busy),
    .done     (done),
    .resultado(resultado),
    .zero     (zero)
  );

  typedef struct {
    string       name;
    logic [71:0] m;
    logic [7:0]  res;
    logic        z;
  } vec_t;

  function automatic logic [71:0] pk(
    input int a, input int b, input int c,
    input int d, input int e, input int f,
    input int g, input int h, input int i);
    return {i[7:0], h[7:0], g[7:0], f[7:0], e[7:0],
            d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  // Full-precision integer determinant, reduced mod 256 at the end.
  function automatic logic [7:0] ref_det(input logic [71:0] m);
    int e [9];
    int d;
    for (int k = 0; k < 9; k++) e[k] = int'($signed(m[8*k +: 8]));
    d = e[0] * (e[4] * e[8] - e[5] * e[7])
      - e[1] * (e[3] * e[8] - e[5] * e[6])
      + e[2] * (e[3] * e[7] - e[4] * e[6]);
    return d[7:0];
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Issue one start, observe cycles 1..12 after acceptance.
  task automatic run(input logic [71:0] m, output logic [7:0] r,
                     output logic z, output int nb, output int nd,
                     output int lat, output int ovl);
    r = 'x; z = 'x; nb = 0; nd = 0; lat = 0; ovl = 0;
    @(negedge clk);
    matriz = m;
    start  = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) nb++;
      if (done && busy) ovl++;
      if (done) begin
        nd++;
        if (lat == 0) lat = n;
        r = resultado;
        z = zero;
      end
    end
  endtask

  vec_t tbl [5];
  logic [7:0]  r;
  logic        z;
  int          nb, nd, lat, ovl;
  logic [71:0] rm;
  logic [71:0] id_m, d2_m, m201;
  int          dn, d1, d2;
  logic [7:0]  r1, r2;

  initial begin
    id_m = pk(1, 0, 0, 0, 1, 0, 0, 0, 1);
    d2_m = pk(2, 0, 0, 0, 2, 0, 0, 0, 2);
    m201 = pk(2, 0, 1, 1, 3, 2, 1, 1, 2);
    tbl[0] = '{"ident", id_m, 8'd1, 1'b0};
    tbl[1] = '{"r123", pk(1, 2, 3, 4, 5, 6, 7, 8, 9), 8'd0, 1'b1};
    tbl[2] = '{"r201", m201, 8'd6, 1'b0};
    tbl[3] = '{"neg", pk(-1, 0, 0, 0, 2, 0, 0, 0, 3), 8'hFA, 1'b0};
    tbl[4] = '{"wrap", pk(10, 0, 0, 0, 10, 0, 0, 0, 10), 8'd232, 1'b0};

    rst = 1'b1;
    start = 1'b1;
    matriz = id_m;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", resultado, 0);
    chk("rst_zero", zero, 1);
    rst = 1'b0;
    start = 1'b0;

    for (int t = 0; t < 5; t++) begin
      run(tbl[t].m, r, z, nb, nd, lat, ovl);
      chk({tbl[t].name, "_res"}, r, tbl[t].res);
      chk({tbl[t].name, "_zero"}, z, tbl[t].z);
      chk({tbl[t].name, "_lat"}, lat, 10);
      chk({tbl[t].name, "_busy"}, nb, 9);
      chk({tbl[t].name, "_ndone"}, nd, 1);
      chk({tbl[t].name, "_ovl"}, ovl, 0);
    end

    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < 9; k++) rm[8*k +: 8] = 8'($urandom);
      if (t == 0) rm = {9{8'h80}};
      if (t == 1) rm = {9{8'hFF}};
      run(rm, r, z, nb, nd, lat, ovl);
      chk("rand_res", r, ref_det(rm));
      chk("rand_zero", z, ref_det(rm) == 8'h00);
      chk("rand_lat", lat, 10);
    end

    // Ignored start mid-op, then back-to-back start in the DONE cycle.
    dn = 0; d1 = 0; d2 = 0; r1 = 'x; r2 = 'x;
    @(negedge clk);
    matriz = id_m;
    start = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        dn++;
        if (dn == 1) begin d1 = n; r1 = resultado; end
        if (dn == 2) begin d2 = n; r2 = resultado; end
      end
      if (n == 3) begin start = 1'b1; matriz = d2_m; end
      if (n == 4) matriz = pk(5, 5, 5, 5, 5, 5, 5, 5, 5);
      if (n == 10 && done) begin start = 1'b1; matriz = d2_m; end
      if (n == 11) matriz = id_m;
    end
    chk("hs_r1", r1, 1);
    chk("hs_t1", d1, 10);
    chk("b2b_r2", r2, 8);
    chk("b2b_t2", d2, 20);
    chk("hs_ndone", dn, 2);

    // Reset mid-operation.
    dn = 0;
    @(negedge clk);
    matriz = m201;
    start = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) dn++;
      if (n == 5) begin
        chk("ab_busy", busy, 0);
        chk("ab_res", resultado, 0);
        chk("ab_zero", zero, 1);
      end
      rst = (n == 4);
    end
    rst = 1'b0;
    chk("ab_ndone", dn, 0);

    run(m201, r, z, nb, nd, lat, ovl);
    chk("post_res", r, 6);
    chk("post_lat", lat, 10);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
